// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and default sizing for the round-robin arbiter
package arb_pkg;
   typedef enum logic {IDLE, GRANT} state_t;
   localparam int N_DEF        = 8;
   localparam int IDXW_DEF     = 3;
   localparam int MAX_HOLD_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first requester at or after ptr (wrapping)
//   req      in   N     request vector
//   ptr      in   IDXW  highest-priority index
//   pick     out  N     one-hot winner (0 when no request)
//   pick_idx out  IDXW  binary index of winner
//   any      out  1     at least one request
module rr_pick
   import arb_pkg::*;
#(
   parameter int N    = N_DEF,
   parameter int IDXW = IDXW_DEF
) (
   input  logic [N-1:0]    req,
   input  logic [IDXW-1:0] ptr,
   output logic [N-1:0]    pick,
   output logic [IDXW-1:0] pick_idx,
   output logic            any
);
   logic [N-1:0] masked, cand;
   // requests at or above ptr win; if none, fall back to the full vector (wrap)
   always_comb begin
      masked   = req & ({N{1'b1}} << ptr);
      cand     = |masked ? masked : req;
      pick_idx = '0;
      for (int i = N - 1; i >= 0; i--) pick_idx = cand[i] ? IDXW'(i) : pick_idx;
      any      = |req;
      pick     = any ? (N'(1) << pick_idx) : '0;
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter, registered one-hot grant held until released
//   clk, rst (sync, active-high)
//   req      in   N     level requests
//   done     in   1     owner releases grant
//   gnt      out  N     one-hot grant
//   gnt_idx  out  IDXW  binary index of grant (drives datapath select)
//   gnt_vld  out  1     grant active
//   timeout  out  1     one-cycle pulse on forced release
// Optional ARB_TIMEOUT_EN: force release after MAX_HOLD grant cycles.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = N_DEF,
   parameter int IDXW     = IDXW_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            done,
   output logic [N-1:0]    gnt,
   output logic [IDXW-1:0] gnt_idx,
   output logic            gnt_vld,
   output logic            timeout
);
   state_t          state, state_nx;
   logic [IDXW-1:0] ptr, pick_idx;
   logic [N-1:0]    pick;
   logic            any, rel, expire, force_rel;

   rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
      .req(req), .ptr(ptr), .pick(pick), .pick_idx(pick_idx), .any(any)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(MAX_HOLD + 1);
   logic [CW-1:0] cnt;
   // zero on the first grant cycle, so expiry lands on the MAX_HOLD-th cycle held
   always_ff @(posedge clk) cnt <= (rst || state == IDLE) ? '0 : cnt + 1'b1;
   assign expire = state == GRANT && cnt == CW'(MAX_HOLD - 1);
`else
   assign expire = 1'b0;
`endif

   // a normal release on the expiry cycle wins, so timeout stays low then
   always_comb begin
      rel       = state == GRANT && (done || !req[gnt_idx]);
      force_rel = expire && !rel;
      state_nx  = state == IDLE ? (any ? GRANT : IDLE) : ((rel || force_rel) ? IDLE : GRANT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
         gnt_vld <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nx;
         timeout <= force_rel;
         if (state == IDLE && any) begin
            gnt     <= pick;
            gnt_idx <= pick_idx;
            gnt_vld <= 1'b1;
         end else if (rel || force_rel) begin
            gnt     <= '0;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx == IDXW'(N - 1) ? '0 : gnt_idx + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: randomized + directed bench for rr_arbiter with a grant scoreboard
module tb_rr_arbiter;
   localparam int N = 8, IDXW = 3, MAX_HOLD = 16;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0, rst = 1'b1, done = 1'b0;
   logic [N-1:0]    req = '0, gnt;
   logic [IDXW-1:0] gnt_idx;
   logic            gnt_vld, timeout;

   rr_arbiter #(.N(N), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rst(rst), .req(req), .done(done),
      .gnt(gnt), .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int cmp = 0, bad = 0;
   bit run = 1'b0;
   int exp_q[$];

   task automatic check(input string nm, input int act, input int exp);
      cmp++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference model: who owns the resource, whose turn is next, how long held
   bit m_busy = 0, m_to = 0;
   int m_owner = 0, m_ptr = 0, m_hold = 0;

   function automatic int first_from(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_busy = 0; m_to = 0; m_ptr = 0; m_hold = 0;
      end else if (!m_busy) begin
         m_to = 0;
         if (req != 0) begin
            m_owner = first_from(req, m_ptr);
            m_busy  = 1;
            m_hold  = 0;
            exp_q.push_back(m_owner);
         end
      end else begin
         m_hold++;
         m_to = 0;
         if (done || !req[m_owner]) begin
            m_busy = 0; m_ptr = (m_owner + 1) % N;
         end else if (TO_EN && m_hold == MAX_HOLD) begin
            m_busy = 0; m_ptr = (m_owner + 1) % N; m_to = 1;
         end
      end
   end

   // monitor: per-cycle invariants, and a scoreboard pop on each new grant
   bit prev_vld = 0;
   always @(negedge clk) begin
      if (run) begin
         check("gnt_vld", int'(gnt_vld), int'(m_busy));
         check("vld_eq_or", int'(gnt_vld), int'(|gnt));
         check("onehot", int'($countones(gnt) <= 1), 1);
         check("timeout", int'(timeout), int'(m_to));
         if (gnt_vld && !prev_vld) begin
            if (exp_q.size() == 0) check("unexpected_grant", int'(gnt_idx), -1);
            else begin
               automatic int e = exp_q.pop_front();
               check("gnt_idx", int'(gnt_idx), e);
               check("gnt_onehot_val", int'(gnt), 1 << e);
            end
         end
         prev_vld = gnt_vld;
      end
   end

   task automatic drive(input logic [N-1:0] r, input logic d, input logic rs, input int n);
      repeat (n) begin
         @(negedge clk);
         req = r; done = d; rst = rs;
      end
   endtask

   initial begin
      req = 8'hFF;
      @(posedge clk);
      #1 run = 1'b1;
      drive(8'hFF, 0, 1, 2);                      // reset with all requests up
      drive(8'hFF, 0, 0, 3);                      // grant 0 one cycle after release
      drive(8'hFF, 1, 0, 20);                     // rotation with done each cycle
      drive(8'h00, 1, 0, 3);
      drive(8'h20, 0, 0, 2);                      // grant 5 -> ptr 6
      drive(8'h00, 0, 0, 2);
      drive(8'h09, 0, 0, 3);                      // wrap to 0
      drive(8'h09, 1, 0, 1);
      drive(8'h09, 0, 0, 3);                      // then 3
      drive(8'h00, 0, 0, 2);
      drive(8'h04, 0, 0, 3);                      // grant 2, drop req to release
      drive(8'hFB, 0, 0, 4);                      // next from 3
      drive(8'h00, 0, 0, 3);
      drive(8'h10, 0, 0, 3);                      // grant 4, reset mid-grant
      drive(8'h30, 0, 1, 1);
      drive(8'h30, 0, 0, 3);                      // ptr back at 0 -> 4
      drive(8'h00, 0, 0, 3);
      drive(8'h03, 0, 0, 110);                    // hold / timeout behaviour
      drive(8'h00, 0, 0, 3);
      for (int i = 0; i < 2000; i++) begin
         automatic logic [N-1:0] r = ($urandom_range(0, 1) == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
         drive(r, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0, 1);
      end
      drive(8'h00, 1, 0, 4);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
